irda_sir_tx_ctrl: RTL

Transmit-side controller for the IrDA SIR path. It accepts a byte over a valid/ready handshake and sequences a UART-style frame: start bit, 8 data bits LSB first, then stop bit. It drives an internal prescaler, a 0..15 sample counter and a bit counter. The output is RZI pulse-encoded: a logical 0 is a 3/16-bit-time pulse, a logical 1 is no pulse. It sits between the byte source (host/FIFO) and the IR LED driver.

---
 rtl/irda_sir_tx_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/irda_sir_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irda_sir_tx_ctrl
// Brief    : IrDA SIR transmit sequencer: start + 8 data (LSB first) + stop,
//            RZI encoded (3/16-bit-time pulse per 0 bit). Optional macro:
//            IRDA_TX_PARITY_EN inserts an even-parity bit before the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module irda_sir_tx_ctrl #(
  parameter logic [15:0] DIV = 16'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ir_tx
);

`ifdef IRDA_TX_PARITY_EN
  localparam logic [3:0] FRAME_BITS = 4'd11;
`else
  localparam logic [3:0] FRAME_BITS = 4'd10;
`endif
  localparam int          c_sh_w     = int'(FRAME_BITS);
  localparam logic [3:0]  c_last_bit = FRAME_BITS - 4'd1;
  localparam logic [15:0] c_div_last = DIV - 16'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_presc, w_presc_nxt;
  logic [3:0]          r_samp, w_samp_nxt;
  logic [3:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic [c_sh_w-1:0]   r_shreg, w_shreg_nxt, w_load;
  logic                w_accept, w_tick, w_ir_nxt;

`ifdef IRDA_TX_PARITY_EN
  assign w_load = {1'b1, ^tx_data, tx_data, 1'b0};
`else
  assign w_load = {1'b1, tx_data, 1'b0};
`endif

  always_comb begin
    // tx_ready is registered high exactly in IDLE and DONE, never right after reset
    w_accept      = tx_ready && tx_valid && ena;
    w_tick        = (r_state == S_SHIFT) && ena && (r_presc == c_div_last);
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_samp_nxt    = r_samp;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shreg_nxt   = r_shreg;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          w_state_nxt   = S_SHIFT;
          w_shreg_nxt   = w_load;
          w_presc_nxt   = 16'd0;
          w_samp_nxt    = 4'd0;
          w_bit_cnt_nxt = 4'd0;
        end
      end
      S_SHIFT: begin
        if (ena) begin
          if (w_tick) begin
            w_presc_nxt = 16'd0;
            if (r_samp == 4'd15) begin
              w_samp_nxt = 4'd0;
              if (r_bit_cnt == c_last_bit) begin
                w_state_nxt = S_DONE;
                w_shreg_nxt = '1;
              end else begin
                w_shreg_nxt   = {1'b1, r_shreg[c_sh_w-1:1]};
                w_bit_cnt_nxt = r_bit_cnt + 4'd1;
              end
            end else begin
              w_samp_nxt = r_samp + 4'd1;
            end
          end else begin
            w_presc_nxt = r_presc + 16'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Pulse decision looks at the upcoming position so the first pulse lands in E+1
    w_ir_nxt = (w_state_nxt == S_SHIFT) && ena && !w_shreg_nxt[0] && (w_samp_nxt <= 4'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_presc   <= 16'd0;
      r_samp    <= 4'd0;
      r_bit_cnt <= 4'd0;
      r_shreg   <= '1;
      ir_tx     <= 1'b0;
      tx_done   <= 1'b0;
      tx_busy   <= 1'b0;
      tx_ready  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_samp    <= w_samp_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shreg   <= w_shreg_nxt;
      ir_tx     <= w_ir_nxt;
      tx_done   <= (w_state_nxt == S_DONE);
      tx_busy   <= (w_state_nxt == S_SHIFT);
      tx_ready  <= (w_state_nxt != S_SHIFT);
    end
  end

endmodule
`default_nettype wire
